// File: rtl/strela_pkg.sv
// Shared definitions for the STRELA memory-side blocks: default sizing
// of the output path and the registered AXI write slot.
package strela_pkg;

   localparam int unsigned STRELA_MAX_OUTSTANDING   = 6;
   localparam int unsigned STRELA_OUTPUT_FIFO_DEPTH = 4;

   // One registered AXI write: 64-bit aligned address, replicated word, lane strobes
   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } wr_slot_t;

   // A 32-bit word lands in the low or high half of the 64-bit beat depending on addr[2]
   function automatic wr_slot_t make_slot(input logic [31:0] byte_addr, input logic [31:0] word);
      wr_slot_t s;
      s.addr = {byte_addr[31:3], 3'b000};
      s.data = {word, word};
      s.strb = byte_addr[2] ? 8'hF0 : 8'h0F;
      return s;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous single-clock FIFO with flush; push is ignored when full and
// pop is ignored when empty. Contents are cleared on reset.
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_rd;
   logic [PW-1:0]         r_wr;
   logic [CW-1:0]         r_cnt;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (r_cnt == CW'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = r_mem[r_rd];

   // Storage, pointers and occupancy; flush empties the queue without touching storage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < int'(DEPTH); k++) r_mem[k] <= '0;
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (flush_i) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= data_i;
            r_wr        <= ptr_inc(r_wr);
         end
         if (w_pop) r_rd <= ptr_inc(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: searches requests starting at the stored priority
// position, wrapping at N; priority moves one past each grant.
module round_robin_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 enable_i,
   input  logic [N-1:0]                         request_i,
   output logic [N-1:0]                         grant_o,
   output logic                                 grant_valid_o,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx_o
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] r_prio;
   logic          w_found;
   int unsigned   w_pos;

   // First requester at or after the priority pointer wins
   always_comb begin
      w_found     = 1'b0;
      w_pos       = 0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_pos = 32'(r_prio) + k;
         if (w_pos >= N) w_pos = w_pos - N;
         if (enable_i && !w_found && request_i[IW'(w_pos)]) begin
            w_found               = 1'b1;
            grant_o[IW'(w_pos)]   = 1'b1;
            grant_idx_o           = IW'(w_pos);
         end
      end
      grant_valid_o = w_found;
   end

   // Priority pointer advances to the node after the last grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_prio <= '0;
      end else if (w_found) begin
         r_prio <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/data_output_writer.sv
// Collects CGRA output streams into per-node FIFOs and writes them to
// memory over an AXI write channel, one 32-bit word per 64-bit beat.
module data_output_writer
   import strela_pkg::*;
#(
   parameter int unsigned OUTPUT_NODES_NUM  = 4,
   parameter int unsigned OUTPUT_FIFO_DEPTH = STRELA_OUTPUT_FIFO_DEPTH,
   parameter int unsigned MAX_OUTSTANDING   = STRELA_MAX_OUTSTANDING
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            execute_i,
   input  logic [32*OUTPUT_NODES_NUM-1:0]  data_output_i,
   input  logic [OUTPUT_NODES_NUM-1:0]     data_output_valid_i,
   output logic [OUTPUT_NODES_NUM-1:0]     data_output_ready_o,
   input  logic [32*OUTPUT_NODES_NUM-1:0]  data_output_addr_i,
   input  logic [16*OUTPUT_NODES_NUM-1:0]  data_output_size_i,
   input  logic [16*OUTPUT_NODES_NUM-1:0]  data_output_stride_i,
   output logic [31:0]                     aw_addr_o,
   output logic [2:0]                      aw_prot_o,
   output logic                            aw_valid_o,
   input  logic                            aw_ready_i,
   output logic [63:0]                     w_data_o,
   output logic [7:0]                      w_strb_o,
   output logic                            w_valid_o,
   input  logic                            w_ready_i,
   input  logic [1:0]                      b_resp_i,
   input  logic                            b_valid_i,
   output logic                            b_ready_o,
   output logic                            done_o,
   output logic                            error_o
);

   localparam int unsigned N    = OUTPUT_NODES_NUM;
   localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]     r_offset [N];
   wr_slot_t        r_slot;
   logic            r_aw_valid;
   logic            r_w_valid;
   logic            r_active;
   logic            r_done;
   logic            r_error;
   logic [CNTW-1:0] r_outstanding;

   logic [31:0]     w_word   [N];
   logic [31:0]     w_base   [N];
   logic [15:0]     w_size   [N];
   logic [15:0]     w_stride [N];
   logic [N-1:0]    w_full;
   logic [N-1:0]    w_empty;
   logic [N-1:0]    w_push;
   logic [N-1:0]    w_eligible;
   logic [N-1:0]    w_grant;
   logic            w_grant_valid;
   logic [IW-1:0]   w_grant_idx;
   logic            w_slot_free;
   logic [CNTW:0]   w_cnt_eff;
   logic            w_arb_en;
   logic [31:0]     w_byte_addr;
   logic            w_all_complete;

   assign aw_prot_o           = 3'b000;
   assign b_ready_o           = 1'b1;
   assign aw_addr_o           = r_slot.addr;
   assign w_data_o            = r_slot.data;
   assign w_strb_o            = r_slot.strb;
   assign aw_valid_o          = r_aw_valid;
   assign w_valid_o           = r_w_valid;
   assign done_o              = r_done;
   assign error_o             = r_error;

   for (genvar g = 0; g < int'(N); g++) begin : g_node
      assign w_base[g]   = data_output_addr_i[32*g +: 32];
      assign w_size[g]   = data_output_size_i[16*g +: 16];
      assign w_stride[g] = data_output_stride_i[16*g +: 16];

      assign data_output_ready_o[g] = r_active & ~w_full[g];
      assign w_push[g]              = data_output_valid_i[g] & data_output_ready_o[g];
      assign w_eligible[g]          = ~w_empty[g] & (r_offset[g] < {16'h0000, w_size[g]});

      fifo_v3 #(
         .DATA_WIDTH (32),
         .DEPTH      (OUTPUT_FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (execute_i),
         .full_o  (w_full[g]),
         .empty_o (w_empty[g]),
         .data_i  (data_output_i[32*g +: 32]),
         .push_i  (w_push[g]),
         .data_o  (w_word[g]),
         .pop_i   (w_grant[g])
      );
   end

   // The slot is free if whatever it holds is handed off on this edge, so grants can run back to back
   assign w_slot_free = ~(r_aw_valid & ~aw_ready_i) & ~(r_w_valid & ~w_ready_i);
   // A B response arriving this cycle already frees its credit for the next grant
   assign w_cnt_eff   = {1'b0, r_outstanding} - {{CNTW{1'b0}}, b_valid_i};
   assign w_arb_en    = r_active & w_slot_free & (w_cnt_eff < (CNTW + 1)'(MAX_OUTSTANDING));
   assign w_byte_addr = w_base[w_grant_idx] + r_offset[w_grant_idx];

   round_robin_arbiter #(
      .N (N)
   ) u_arb (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .enable_i      (w_arb_en),
      .request_i     (w_eligible),
      .grant_o       (w_grant),
      .grant_valid_o (w_grant_valid),
      .grant_idx_o   (w_grant_idx)
   );

   // Completion: every stream reached its size and nothing is left on the bus
   always_comb begin
      w_all_complete = ~r_aw_valid & ~r_w_valid & (r_outstanding == '0);
      for (int g = 0; g < int'(N); g++) begin
         if (r_offset[g] < {16'h0000, w_size[g]}) w_all_complete = 1'b0;
      end
   end

   // Write slot: load on grant, AW and W valids retire independently on their handshakes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_slot     <= '0;
         r_aw_valid <= 1'b0;
         r_w_valid  <= 1'b0;
      end else if (w_grant_valid) begin
         r_slot     <= make_slot(w_byte_addr, w_word[w_grant_idx]);
         r_aw_valid <= 1'b1;
         r_w_valid  <= 1'b1;
      end else begin
         if (aw_ready_i) r_aw_valid <= 1'b0;
         if (w_ready_i)  r_w_valid  <= 1'b0;
      end
   end

   // Per-node byte offsets: restart on execute, advance by stride on each grant
   always_ff @(posedge clk_i) begin
      if (rst_i || execute_i) begin
         for (int g = 0; g < int'(N); g++) r_offset[g] <= '0;
      end else if (w_grant_valid) begin
         r_offset[w_grant_idx] <= r_offset[w_grant_idx] + {16'h0000, w_stride[w_grant_idx]};
      end
   end

   // Writes awaiting a B response; survives execute so late responses still balance
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_outstanding <= '0;
      end else begin
         case ({w_grant_valid, b_valid_i})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Run control: execute starts a run and clears status, completion ends it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_active <= 1'b0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else if (execute_i) begin
         r_active <= 1'b1;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         if (r_active && w_all_complete) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
         end
         if (b_valid_i && (b_resp_i != 2'b00)) r_error <= 1'b1;
      end
   end

   a_b_without_write : assert property (@(posedge clk_i) disable iff (rst_i)
      !(b_valid_i && (r_outstanding == '0)));

   a_outstanding_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_grant_valid && !b_valid_i && (r_outstanding >= CNTW'(MAX_OUTSTANDING))));

endmodule

// File: doc/data_output_writer.md
DATA_OUTPUT_WRITER -- requirements
Module: data_output_writer

Interface
REQ-001 SHALL have parameter OUTPUT_NODES_NUM, default 4, number of CGRA output streams.
REQ-002 SHALL have parameter OUTPUT_FIFO_DEPTH, default 4, words per per-node FIFO.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 6, max writes awaiting B response.
REQ-004 SHALL have ports, in order (N = OUTPUT_NODES_NUM):
- clk_i  in  1  sole clock; one clock, all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- execute_i  in  1  one-cycle start pulse.
- data_output_i  in  32*N  CGRA output words, node i at [32i+31:32i].
- data_output_valid_i  in  N  per-node valid.
- data_output_ready_o  out  N  per-node ready.
- data_output_addr_i  in  32 x N  base byte address.
- data_output_size_i  in  16 x N  bytes to write.
- data_output_stride_i  in  16 x N  byte increment per word.
- aw_addr_o 32 out, aw_prot_o 3 out, aw_valid_o 1 out, aw_ready_i 1 in.
- w_data_o 64 out, w_strb_o 8 out, w_valid_o 1 out, w_ready_i 1 in.
- b_resp_i 2 in, b_valid_i 1 in, b_ready_o 1 out.
- done_o  out  1  all streams written and acknowledged.
- error_o  out  1  sticky: non-OKAY B response seen.

Function
REQ-005 SHALL drive aw_prot_o = 0 and b_ready_o = 1 constantly.
REQ-006 SHALL keep an active flag: set by execute_i; cleared when done_o asserts. While inactive, no grants are issued.
REQ-007 SHALL, on execute_i, zero all per-node 32-bit offsets, flush all node FIFOs, clear error_o and done_o. Outstanding count and any in-flight AW/W are NOT discarded.
REQ-008 SHALL buffer each node in its own FIFO; data_output_ready_o[i] = active & !full[i]; push on valid & ready.
REQ-009 SHALL mark node i eligible when its FIFO is non-empty and offset[i] < zero-extended size[i].
REQ-010 SHALL pick one eligible node per cycle with a round-robin arbiter, starting one position after the last grant, wrapping at N; the initial priority after reset is node 0.
REQ-011 SHALL enable the arbiter only when the write slot is free (REQ-014) and outstanding + in-flight < MAX_OUTSTANDING.
REQ-012 SHALL, on a grant to node i in cycle t:
- pop FIFO i;
- register addr = addr_i + offset[i];
- set offset[i] += zero-extended stride[i], 32-bit wrap;
- register aw_addr_o = {addr[31:3], 3'b000}, w_data_o = {word, word}, w_strb_o = addr[2] ? 8'hF0 : 8'h0F;
- raise aw_valid_o and w_valid_o in cycle t+1;
- increment the outstanding count.
REQ-013 SHALL hold aw_valid_o until aw_ready_i, and w_valid_o until w_ready_i, independently; address and data payload stay stable while their valid is high.
REQ-014 SHALL consider the write slot free when neither valid is pending after this cycle's handshakes, allowing back-to-back grants with no idle cycle.
REQ-015 SHALL decrement the outstanding count on each b_valid_i; a simultaneous grant and B leave it unchanged.
REQ-016 SHALL set error_o when b_valid_i and b_resp_i != 0.
REQ-017 SHALL assert done_o (registered, held until next execute_i) when active and all of the following hold:
- offset[i] >= size[i] for every i;
- no AW/W pending;
- outstanding = 0.
REQ-018 SHALL flag by assertion: a B response arriving with outstanding = 0, or a count overflow.
REQ-019 SHALL, with size[i] = 0, treat node i as complete immediately. With stride[i] = 0 and size > 0, node i never completes; the design does not guard this case.

Reset
REQ-020 SHALL, on rst_i, set to 0:
- outputs aw_valid_o, w_valid_o, done_o, error_o;
- data_output_ready_o;
- aw_addr_o, w_data_o, w_strb_o;
- active, offsets, outstanding count, FIFO contents.
It SHALL reset arbiter priority to node 0; reset mid-transfer abandons it silently.

Structure
REQ-021 SHALL take MAX_OUTSTANDING and OUTPUT_FIFO_DEPTH defaults, plus any write-slot typedef, from the shared strela package.
REQ-022 SHALL instantiate the existing round_robin_arbiter and fifo_v3; no new sub-module.

Verification
REQ-023 One node, addr 0x1000, size 8, stride 4, words A, B, ready AXI:
- writes to 0x1000 strb 0F data {A,A}, then 0x1000 strb F0 data {B,B};
- done_o asserts after second B.
REQ-024 4 nodes all valid, size 4: grants in order 0, 1, 2, 3, one per cycle.
REQ-025 aw_ready_i low 3 cycles, w_ready_i immediate: aw_addr_o stable; no new grant until AW accepted.
REQ-026 B held low with stream longer than 6 words: exactly 6 AWs issued; the 7th issues the cycle after the first B.
REQ-027 b_resp_i = 2'b10 on one response: error_o = 1 and stays high; cleared by the next execute_i.
REQ-028 rst_i mid-stream, then execute_i: all outputs 0 after reset; the new run starts at offset 0.
